// File: rtl/scnn_output_drain.sv
// scnn_output_drain
//   Post-processing and drain stage behind the convolution controller. On start it snapshots
//   NUM_OUT signed accumulators and applies ReLU and a right-shift requantization with
//   saturation to OUT_W bits. It then streams the surviving non-zero values as (value, index)
//   pairs over a valid/ready handshake.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             capture acc_in/shift and begin a tile; honoured only when idle
//   acc_in, shift     signed accumulators and requantization shift (0..31)
//   busy              high whenever a tile is in progress
//   out_valid/ready   output handshake; out_data/out_idx/out_last form the beat
//   done              one-cycle pulse at end of tile
//   nz_count          beats accepted this tile, held until the next start
module scnn_output_drain #(
    parameter int unsigned NUM_OUT = 64,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned IDX_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_OUT-1:0][ACC_W-1:0]   acc_in,
    input  logic [4:0]                      shift,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_data,
    output logic [IDX_W-1:0]                out_idx,
    output logic                            out_last,
    output logic                            done,
    output logic [IDX_W-1:0]                nz_count
);

    localparam int unsigned PtrW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [ACC_W-1:0] SatMax  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    // ReLU, logical right shift, then clamp to the largest positive OUT_W value.
    function automatic logic [OUT_W-1:0] quantize(input logic [ACC_W-1:0] acc,
                                                  input logic [4:0]       sh);
        logic [ACC_W-1:0] mag;
        logic [OUT_W-1:0] res;
        mag = acc >> sh;
        if (acc[ACC_W-1]) begin
            res = '0;
        end else if (mag > SatMax) begin
            res = SatMax[OUT_W-1:0];
        end else begin
            res = mag[OUT_W-1:0];
        end
        return res;
    endfunction

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [NUM_OUT-1:0][OUT_W-1:0]  q_q, q_d;
    logic [NUM_OUT-1:0]             mask_q, mask_d;
    logic                           out_valid_q, out_valid_d;
    logic [OUT_W-1:0]               out_data_q, out_data_d;
    logic [IDX_W-1:0]               out_idx_q, out_idx_d;
    logic                           out_last_q, out_last_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;
    logic [IDX_W-1:0]               nz_count_q, nz_count_d;

    logic [NUM_OUT-1:0][OUT_W-1:0]  q_snap;
    logic [NUM_OUT-1:0]             mask_snap;
    logic [NUM_OUT-1:0]             above;
    logic [PtrW-1:0]                ptr_sel;
    logic                           elem_nz;
    logic                           is_last;
    logic                           handshake;
    logic                           slot_free;

    always_comb begin
        q_snap    = '0;
        mask_snap = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            q_snap[k]    = quantize(acc_in[k], shift);
            mask_snap[k] = |q_snap[k];
        end
    end

    assign ptr_sel   = ptr_q[PtrW-1:0];
    assign elem_nz   = mask_q[ptr_sel];
    // The current element is the last non-zero if nothing is set above it.
    assign above     = mask_q >> ptr_q;
    assign is_last   = ~|above[NUM_OUT-1:1];
    assign handshake = out_valid_q & out_ready;
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        q_d         = q_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        nz_count_d  = nz_count_q;

        if (handshake) begin
            out_valid_d = 1'b0;
            nz_count_d  = nz_count_q + IDX_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    q_d        = q_snap;
                    mask_d     = mask_snap;
                    nz_count_d = '0;
                    ptr_d      = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (elem_nz && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = q_q[ptr_sel];
                    out_idx_d   = ptr_q;
                    out_last_d  = is_last;
                end
                // Only a non-zero element waiting on an occupied slot stalls the pointer.
                if (!elem_nz || slot_free) begin
                    if (ptr_q == LastIdx) begin
                        ptr_d   = '0;
                        // Skip DRAIN when nothing is left in the output slot.
                        state_d = out_valid_d ? StDrain : StDone;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!out_valid_d) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            q_q         <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            nz_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            q_q         <= q_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            nz_count_q  <= nz_count_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign nz_count  = nz_count_q;

endmodule

// File: tb/tb_scnn_output_drain.sv
// tb_scnn_output_drain
//   Directed tiles for scnn_output_drain. Stimulus pushes the hand-computed beats into a
//   scoreboard queue; a negedge monitor pops and compares every accepted beat and checks
//   that a stalled beat stays stable.
module tb_scnn_output_drain;

    localparam int unsigned NumOut = 64;
    localparam int unsigned AccW   = 32;
    localparam int unsigned OutW   = 16;
    localparam int unsigned IdxW   = 8;

    typedef struct packed {
        logic [OutW-1:0] data;
        logic [IdxW-1:0] idx;
        logic            last;
    } beat_t;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic [NumOut-1:0][AccW-1:0]  acc_in;
    logic [4:0]                   shift;
    logic                         busy;
    logic                         out_valid;
    logic                         out_ready;
    logic [OutW-1:0]              out_data;
    logic [IdxW-1:0]              out_idx;
    logic                         out_last;
    logic                         done;
    logic [IdxW-1:0]              nz_count;

    beat_t                        sb[$];
    int                           n_checks = 0;
    int                           n_fail = 0;
    int                           cyc = 0;
    int                           start_cyc = 0;
    int                           last_hs_cyc = 0;
    logic                         hold_q = 1'b0;
    beat_t                        held;
    logic [NumOut-1:0][AccW-1:0]  v;
    logic [NumOut-1:0][AccW-1:0]  v3;

    scnn_output_drain #(
        .NUM_OUT (NumOut),
        .ACC_W   (AccW),
        .OUT_W   (OutW),
        .IDX_W   (IdxW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_in    (acc_in),
        .shift     (shift),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .nz_count  (nz_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push(input int data, input int idx, input bit last);
        beat_t b;
        b.data = OutW'(data);
        b.idx  = IdxW'(idx);
        b.last = last;
        sb.push_back(b);
    endtask

    // Monitor: scoreboard pop on every handshake, stability of a stalled beat.
    always @(negedge clk) begin
        beat_t exp_b;
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_data, out_idx, out_last}, held);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("beat_data", out_data, exp_b.data);
                    check("beat_idx", out_idx, exp_b.idx);
                    check("beat_last", out_last, exp_b.last);
                end
                last_hs_cyc = cyc;
            end
            hold_q = out_valid && !out_ready;
            held   = {out_data, out_idx, out_last};
        end
    end

    task automatic start_tile(input logic [NumOut-1:0][AccW-1:0] vec, input logic [4:0] sh);
        @(posedge clk);
        #1;
        acc_in    = vec;
        shift     = sh;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // exp_lat >= 0: done must land exp_lat cycles after start; otherwise one after the last beat.
    task automatic wait_done(input int exp_lat);
        bit got = 1'b0;
        int dcyc = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen", got, 1);
        if (exp_lat >= 0) check("done_cycle", dcyc - start_cyc, exp_lat);
        else check("done_after_last_beat", dcyc, last_hs_cyc + 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_nz"}, nz_count, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        acc_in    = '0;
        shift     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-zero tile: no beats, done at cycle 65.
        v = '0;
        start_tile(v, 5'd0);
        check("busy_cycle1", busy, 1);
        wait_done(65);
        check("nz_all_zero", nz_count, 0);

        // Single non-zero at index 5.
        v = '0;
        v[5] = 32'd300;
        push(300, 5, 1'b1);
        start_tile(v, 5'd0);
        wait_done(65);
        check("nz_single", nz_count, 1);

        // Saturation, ReLU and truncation-to-zero with shift 4.
        v3 = '0;
        v3[0] = 32'h0010_0000;
        v3[1] = 32'hFFFF_FFFB;
        v3[2] = 32'd15;
        v3[3] = 32'h0000_0040;
        push(32767, 0, 1'b0);
        push(4, 3, 1'b1);
        start_tile(v3, 5'd4);
        wait_done(65);
        check("nz_quant", nz_count, 2);

        // All ones with out_ready low over cycles 3..12.
        for (int i = 0; i < NumOut; i++) begin
            v[i] = 32'd1;
            push(1, i, i == NumOut - 1);
        end
        start_tile(v, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_valid", out_valid, 1);
        check("stall_idx", out_idx, 1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(-1);
        check("nz_all_ones", nz_count, 64);

        // Second start mid-tile is ignored; result matches the shift-4 tile.
        push(32767, 0, 1'b0);
        push(4, 3, 1'b1);
        start_tile(v3, 5'd4);
        @(posedge clk);
        #1;
        for (int i = 0; i < NumOut; i++) acc_in[i] = 32'd7;
        shift = 5'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(65);
        check("nz_ignored_start", nz_count, 2);

        // Reset while index 10 is presented.
        for (int i = 0; i < NumOut; i++) begin
            v[i] = 32'd1;
            push(1, i, i == NumOut - 1);
        end
        start_tile(v, 5'd0);
        repeat (11) @(posedge clk);
        #1;
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_idx", out_idx, 10);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", out_valid, 0);

        // Fresh tile after reset, starting from index 0.
        v = '0;
        v[0] = 32'd9;
        v[5] = 32'd300;
        push(9, 0, 1'b0);
        push(300, 5, 1'b1);
        start_tile(v, 5'd0);
        wait_done(65);
        check("nz_after_reset", nz_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
